seq_addsub_n: RTL and testbench
===============================

// Module: seq_addsub_n
// PURPOSE
//  Parametrised multi-cycle adder/subtractor for the CPU datapath: WIDTH-bit operands
//  processed CHUNK bits per clock, LSB slice first, with carry held in a register between slices.
//  Trades latency for a short carry chain.
//  start/done handshake to the control FSM. Reports carry-out and signed overflow.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of CHUNK
//  CHUNK   4  bits added per clock, 1..WIDTH; N = WIDTH/CHUNK slices
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only when busy=0
//  ain    in   WIDTH  operand A, latched on accepted start
//  bin    in   WIDTH  operand B, latched on accepted start
//  cin    in   1      carry/borrow in, latched on accepted start
//  sub    in   1      0: A+B+cin   1: A-B-cin, latched on accepted start
//  busy   out  1      operation in progress
//  done   out  1      one-cycle pulse: result valid
//  s      out  WIDTH  result, held until next completion
//  c      out  1      carry out (sub: 1 = no borrow)
//  v      out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy=0, done=0, s=0, c=0, v=0; internal operands, carry
//    and slice index cleared. Reset mid-operation aborts it; no done follows.
//  - FSM: IDLE -> RUN on start=1 at a clock edge. RUN -> IDLE after slice N-1 is computed.
//  - Accept edge: latch ain, bin, and sub. Latch B' = sub ? ~bin : bin. Latch carry k0 = cin ^ sub.
//    Set idx=0, busy=1.
//  - Each RUN edge: slice idx: {k,r[idx]} = A[idx]+B'[idx]+k (CHUNK+1 bits); idx++.
//  - Latency: done=1 exactly N clocks after the accept edge; busy=0 on that same edge.
//    busy high for N cycles. N=1 (CHUNK=WIDTH) gives single-cycle latency.
//  - On the final edge: s <= full result, c <= final carry.
//    v <= (A[W-1]==B'[W-1]) && (r[W-1]!=A[W-1]).
//  - s, c and v change only on the completion edge or on reset; partial slices are never visible.
//  - start while busy=1: ignored, no queuing, latched operands unaffected.
//  - start on the done edge (busy was 1): ignored; new start accepted from the next cycle.
//  - Input changes on ain/bin/cin/sub after acceptance have no effect on the current operation.
//  - done is never high for two consecutive cycles.
// CONFIGURATION
//  SEQ_ADDSUB_SAT_EN defined: signed saturation on overflow.
//    If v=1, s = A[W-1] ? {1'b1,{W-1{1'b0}}} : {1'b0,{W-1{1'b1}}}.
//    c and v still report the unsaturated result.
//  Not defined: result wraps modulo 2^WIDTH; no saturation logic is synthesised.
// TESTING (WIDTH=16, CHUNK=4 unless noted; cycle count from accept edge)
//  1 ain=0x0005 bin=0x0003 cin=0 sub=0 -> done at +4 clocks: s=0x0008 c=0 v=0; busy high 4 cycles
//  2 ain=0xFFFF bin=0x0001 sub=0 -> s=0x0000 c=1 v=0 (carry ripples through all 4 slices)
//  3 ain=0x0003 bin=0x0005 sub=1 cin=0 -> s=0xFFFE c=0 v=0; same with cin=1 -> s=0xFFFD
//  4 ain=0x7FFF bin=0x0001 sub=0 -> v=1, c=0; s=0x8000 without SEQ_ADDSUB_SAT_EN, 0x7FFF with it
//  5 start pulses on +1,+2 while busy -> ignored, single done with original operands;
//    rst_n=0 at +2 -> all outputs 0 immediately, no done pulse
//  6 CHUNK=WIDTH=8: ain=0x80 bin=0x80 -> done at +1 clock, c=1 v=1; s=0x00 (sat: 0x80)

Source files
------------

// File: rtl/seq_addsub_n.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB slice first.
// Optional signed saturation on overflow: define SEQ_ADDSUB_SAT_EN.
module seq_addsub_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             k_q;
    logic [IW-1:0]    idx;

    logic [31:0]      base;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] r_next;
    logic             v_next;
    logic [WIDTH-1:0] s_final;

    // sub is folded into the latched B' and initial carry, so it needs no register of its own
    always_comb begin
        base      = 32'(idx) * 32'(CHUNK);
        slice_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, k_q};
        r_next    = r_q;
        r_next[base +: CHUNK] = slice_sum[CHUNK-1:0];
        v_next    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_next[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SEQ_ADDSUB_SAT_EN
        if (v_next)
            s_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            s_final = r_next;
`else
        s_final   = r_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            k_q   <= 1'b0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= ain;
                        b_q   <= sub ? ~bin : bin;
                        k_q   <= cin ^ sub;
                        r_q   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r_q <= r_next;
                    k_q <= slice_sum[CHUNK];
                    if (idx == LAST) begin
                        s     <= s_final;
                        c     <= slice_sum[CHUNK];
                        v     <= v_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub_n.sv
// Directed bench for seq_addsub_n: 16/4 and 8/8 instances, scoreboard queue of expected results.
module tb_seq_addsub_n;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start16, cin16, sub16, busy16, done16, c16, v16;
    logic [15:0] ain16, bin16, s16;
    logic        start8, cin8, sub8, busy8, done8, c8, v8;
    logic [7:0]  ain8, bin8, s8;

    int   checks = 0;
    int   fails  = 0;
    res_t sbq[$];

    always #5 clk = ~clk;

    seq_addsub_n #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .ain(ain16), .bin(bin16),
        .cin(cin16), .sub(sub16), .busy(busy16), .done(done16), .s(s16), .c(c16), .v(v16)
    );

    seq_addsub_n #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ain(ain8), .bin(bin8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .s(s8), .c(c8), .v(v8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain full-width arithmetic, independent of slicing
    function automatic res_t model(input int w, input logic [15:0] a, b, input logic ci, sb);
        logic [15:0] mask, bp;
        logic [16:0] sum;
        int          msb;
        res_t        r;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        msb  = w - 1;
        bp   = (sb ? ~b : b) & mask;
        sum  = {1'b0, a & mask} + {1'b0, bp} + {16'b0, ci ^ sb};
        r.s  = sum[15:0] & mask;
        r.c  = sum[w];
        r.v  = (a[msb] == bp[msb]) && (r.s[msb] != a[msb]);
`ifdef SEQ_ADDSUB_SAT_EN
        if (r.v) r.s = a[msb] ? (16'd1 << msb) : ((16'd1 << msb) - 16'd1);
`endif
        return r;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 16) ? busy16 : busy8;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done8;
    endfunction
    function automatic logic [15:0] get_s(input int w);
        return (w == 16) ? s16 : {8'h00, s8};
    endfunction
    function automatic logic get_c(input int w);
        return (w == 16) ? c16 : c8;
    endfunction
    function automatic logic get_v(input int w);
        return (w == 16) ? v16 : v8;
    endfunction

    task automatic drive(input int w, input logic [15:0] a, b, input logic ci, sb, st);
        if (w == 16) begin
            ain16 = a; bin16 = b; cin16 = ci; sub16 = sb; start16 = st;
        end else begin
            ain8 = a[7:0]; bin8 = b[7:0]; cin8 = ci; sub8 = sb; start8 = st;
        end
    endtask

    task automatic drive_rand(input int w, input logic st);
        drive(w, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), st);
    endtask

    // One operation; junk = extra starts at +1/+2, late = start on the done edge
    task automatic run_op(input int w, input logic [15:0] a, b, input logic ci, sb,
                          input bit junk, input bit late);
        int          n, cnt;
        logic [15:0] s_prev;
        res_t        exp;
        n = (w == 16) ? 4 : 1;
        @(negedge clk);
        drive(w, a, b, ci, sb, 1'b1);
        sbq.push_back(model(w, a, b, ci, sb));
        s_prev = get_s(w);
        @(negedge clk);
        cnt = 0;
        while (cnt < 20) begin
            if (get_done(w)) break;
            check("busy_during_run", get_busy(w), 1);
            check("s_held_during_run", get_s(w), s_prev);
            drive_rand(w, (junk && cnt < 2) || (late && cnt == n - 1));
            @(negedge clk);
            cnt++;
        end
        drive_rand(w, 1'b0);
        check("latency", cnt, n);
        check("busy_at_done", get_busy(w), 0);
        exp = sbq.pop_front();
        check("s", get_s(w), exp.s);
        check("c", get_c(w), exp.c);
        check("v", get_v(w), exp.v);
        @(negedge clk);
        check("done_single_pulse", get_done(w), 0);
        check("idle_after_done", get_busy(w), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(16, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(8, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy16", busy16, 0);
        check("rst_done16", done16, 0);
        check("rst_s16", s16, 0);
        check("rst_cv16", {c16, v16}, 0);
        check("rst_s8", {busy8, done8, c8, v8, s8}, 0);
        rst_n = 1'b1;

        run_op(16, 16'h0005, 16'h0003, 1'b0, 1'b0, 0, 0);
        run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16, 16'h0003, 16'h0005, 1'b0, 1'b1, 0, 0);
        run_op(16, 16'h0003, 16'h0005, 1'b1, 1'b1, 0, 0);
        run_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        run_op(16, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0);
        run_op(16, 16'h1234, 16'h1111, 1'b0, 1'b0, 1, 0);
        run_op(16, 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 0, 1);
        run_op(16, 16'hABCD, 16'h1357, 1'b0, 1'b0, 0, 0);

        // Reset two clocks into an operation
        @(negedge clk);
        drive(16, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive_rand(16, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_s", s16, 0);
        check("abort_flags", {busy16, done16, c16, v16}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {busy16, done16}, 0);
        end

        run_op(8, 16'h0080, 16'h0080, 1'b0, 1'b0, 0, 0);
        run_op(8, 16'h0080, 16'h0001, 1'b0, 1'b1, 0, 1);
        run_op(8, 16'h0012, 16'h0034, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++)
            run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 0);

        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
